// File: rtl/bird_motion.sv
// rtl/bird_motion.sv - per-frame bird vertical physics, flap latch, animation and hit box
module bird_motion #(
    parameter int BIRD_X   = 120,
    parameter int BIRD_W   = 48,
    parameter int BIRD_H   = 48,
    parameter int Y_INIT   = 200,
    parameter int GRAVITY  = 1,
    parameter int FLAP_VEL = 8,
    parameter int V_MAX    = 10,
    parameter int GROUND_Y = 425,
    parameter int ANIM_DIV = 8
) (
    input  logic       clk,
    input  logic       RESET,
    input  logic       vs,
    input  logic [9:0] x,
    input  logic [8:0] y,
    input  logic       fly,
    input  logic       game_status,
    input  logic       lose,
    output logic [8:0] bird_y,
    output logic       is_bird,
    output logic [1:0] anim_frame,
    output logic [1:0] state
);
    typedef enum logic [1:0] {IDLE = 2'd0, FLY = 2'd1, DEAD = 2'd2} state_t;

    localparam logic signed [5:0]  FLAP_V  = 6'(-FLAP_VEL);
    localparam logic signed [6:0]  GRAV7   = 7'(GRAVITY);
    localparam logic signed [6:0]  V_CAP7  = 7'(V_MAX);
    localparam logic signed [10:0] Y_MAX11 = 11'(GROUND_Y - BIRD_H);
    localparam logic [8:0]         Y_TOP   = 9'(GROUND_Y - BIRD_H);
    localparam logic [8:0]         Y_RST   = 9'(Y_INIT);
    localparam logic [2:0]         CNT_END = 3'(ANIM_DIV - 1);

    state_t             st;
    logic               vs_d;
    logic               fly_d;
    logic               flap_pending;
    logic signed [5:0]  vel;
    logic [2:0]         anim_cnt;

    logic               tick;
    logic               fly_rise;
    logic               to_dead;
    logic               anim_adv;
    logic signed [6:0]  vel_grav;
    logic signed [5:0]  vel_next;
    logic signed [10:0] ny;
    logic [9:0]         by10;
    logic [9:0]         y10;

    assign tick     = vs_d & ~vs;
    assign fly_rise = fly & ~fly_d;
    assign to_dead  = (st == FLY) && (lose || !game_status);
    assign anim_adv = tick && ((st == IDLE) || (st == FLY && !to_dead));
    assign state    = st;

    // Velocity is settled first, then the position uses the new value
    always_comb begin
        vel_grav = $signed({vel[5], vel}) + GRAV7;
        if (vel_grav > V_CAP7)
            vel_grav = V_CAP7;
        vel_next = (st == FLY && flap_pending) ? FLAP_V : vel_grav[5:0];
        ny       = $signed({2'b00, bird_y}) + $signed({{5{vel_next[5]}}, vel_next});
    end

    // Widened to 10 bits so bird_y + BIRD_H cannot wrap near the bottom rows
    always_comb begin
        by10    = {1'b0, bird_y};
        y10     = {1'b0, y};
        is_bird = (x >= 10'(BIRD_X)) && (x < 10'(BIRD_X + BIRD_W)) &&
                  (y10 >= by10) && (y10 < by10 + 10'(BIRD_H));
    end

    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            st           <= IDLE;
            bird_y       <= Y_RST;
            vel          <= '0;
            anim_frame   <= '0;
            anim_cnt     <= '0;
            flap_pending <= 1'b0;
            vs_d         <= 1'b1;
            fly_d        <= 1'b0;
        end else begin
            vs_d  <= vs;
            fly_d <= fly;
            case (st)
                IDLE: begin
                    bird_y       <= Y_RST;
                    vel          <= '0;
                    flap_pending <= 1'b0;
                    if (tick && game_status)
                        st <= FLY;
                end
                FLY: begin
                    if (to_dead) begin
                        st           <= DEAD;
                        flap_pending <= 1'b0;
                    end else if (tick) begin
                        // A rise coinciding with the tick belongs to the next frame
                        flap_pending <= fly_rise;
                        if (ny[10]) begin
                            bird_y <= '0;
                            vel    <= '0;
                        end else if (ny > Y_MAX11) begin
                            bird_y <= Y_TOP;
                            vel    <= '0;
                        end else begin
                            bird_y <= ny[8:0];
                            vel    <= vel_next;
                        end
                    end else if (fly_rise) begin
                        flap_pending <= 1'b1;
                    end
                end
                DEAD: begin
                    flap_pending <= 1'b0;
                    if (tick) begin
                        if (ny[10]) begin
                            bird_y <= '0;
                            vel    <= '0;
                        end else if (ny > Y_MAX11) begin
                            bird_y <= Y_TOP;
                            vel    <= '0;
                        end else begin
                            bird_y <= ny[8:0];
                            vel    <= vel_next;
                        end
                    end
                end
                default: st <= IDLE;
            endcase
            if (anim_adv) begin
                if (anim_cnt == CNT_END) begin
                    anim_cnt   <= '0;
                    anim_frame <= (anim_frame == 2'd2) ? 2'd0 : anim_frame + 2'd1;
                end else begin
                    anim_cnt <= anim_cnt + 3'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_bird_motion.sv
// tb/tb_bird_motion.sv - self-checking bench for bird_motion
module tb_bird_motion;
    logic       clk = 1'b0;
    logic       RESET;
    logic       vs;
    logic [9:0] x;
    logic [8:0] y;
    logic       fly;
    logic       game_status;
    logic       lose;
    logic [8:0] bird_y;
    logic       is_bird;
    logic [1:0] anim_frame;
    logic [1:0] state;

    bird_motion dut (
        .clk(clk), .RESET(RESET), .vs(vs), .x(x), .y(y), .fly(fly),
        .game_status(game_status), .lose(lose), .bird_y(bird_y),
        .is_bird(is_bird), .anim_frame(anim_frame), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct { int x; int y; bit exp; } vec_t;
    typedef struct { int y; int frame; int st; } exp_t;

    vec_t vt[8];
    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    int m_y, m_vel, m_state, m_cnt, m_frame;
    bit m_pend;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_y = 200; m_vel = 0; m_state = 0; m_cnt = 0; m_frame = 0; m_pend = 0;
    endtask

    task automatic model_place(input int nv);
        int ny;
        ny = m_y + nv;
        if (ny < 0) begin
            m_y = 0; m_vel = 0;
        end else if (ny > 377) begin
            m_y = 377; m_vel = 0;
        end else begin
            m_y = ny; m_vel = nv;
        end
    endtask

    task automatic model_anim();
        m_cnt++;
        if (m_cnt == 8) begin
            m_cnt = 0;
            m_frame = (m_frame + 1) % 3;
        end
    endtask

    task automatic model_tick();
        int nv;
        nv = (m_vel + 1 > 10) ? 10 : m_vel + 1;
        case (m_state)
            0: begin
                m_y = 200; m_vel = 0;
                model_anim();
                if (game_status) m_state = 1;
            end
            1: begin
                if (m_pend) nv = -8;
                model_place(nv);
                model_anim();
            end
            default: model_place(nv);
        endcase
        m_pend = 0;
    endtask

    // pulses: fly pulses before vs falls; co: fly rises in the tick cycle itself
    task automatic do_tick(input int pulses, input bit co);
        exp_t e;
        for (int p = 0; p < pulses; p++) begin
            fly = 1'b1; @(negedge clk);
            fly = 1'b0; @(negedge clk);
        end
        if (pulses > 0 && m_state == 1) m_pend = 1;
        vs = 1'b0;
        if (co) fly = 1'b1;
        model_tick();
        if (co && m_state == 1) m_pend = 1;
        sb.push_back('{m_y, m_frame, m_state});
        @(negedge clk);
        if (sb.size() == 0) begin
            chk("sb_empty", 0, 1);
        end else begin
            e = sb.pop_front();
            chk("tick_bird_y", int'(bird_y), e.y);
            chk("tick_anim", int'(anim_frame), e.frame);
            chk("tick_state", int'(state), e.st);
        end
        vs = 1'b1; fly = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    int ff_exp[4] = '{200, 201, 203, 206};
    int pat[$];
    int frame_at_death;
    int guard;

    initial begin
        vt[0] = '{0,   0,   1'b0};
        vt[1] = '{120, 200, 1'b1};
        vt[2] = '{168, 200, 1'b0};
        vt[3] = '{120, 248, 1'b0};
        vt[4] = '{119, 200, 1'b0};
        vt[5] = '{167, 247, 1'b1};
        vt[6] = '{120, 199, 1'b0};
        vt[7] = '{140, 230, 1'b1};

        RESET = 1'b1; vs = 1'b1; fly = 1'b0; game_status = 1'b0; lose = 1'b0;
        x = '0; y = '0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_bird_y", int'(bird_y), 200);
        chk("rst_anim", int'(anim_frame), 0);
        chk("rst_state", int'(state), 0);
        for (int i = 0; i < 8; i++) begin
            x = 10'(vt[i].x); y = 9'(vt[i].y);
            #1;
            chk($sformatf("is_bird_%0d_%0d", vt[i].x, vt[i].y), int'(is_bird), int'(vt[i].exp));
        end
        RESET = 1'b0;
        @(negedge clk);

        // free fall from IDLE
        game_status = 1'b1;
        for (int i = 0; i < 4; i++) begin
            do_tick(0, 1'b0);
            chk("fall_bird_y", int'(bird_y), ff_exp[i]);
            chk("fall_state", int'(state), 1);
        end

        // several rising edges in one frame make a single flap
        do_tick(3, 1'b0);
        chk("flap_y", int'(bird_y), 198);
        do_tick(0, 1'b0);
        chk("flap_next_y", int'(bird_y), 191);

        // steer to y=3 and flap into the ceiling
        for (int i = 0; i < 5; i++) do_tick(0, 1'b0);
        chk("steer_y", int'(bird_y), 171);
        for (int i = 0; i < 21; i++) do_tick(1, 1'b0);
        chk("pre_ceiling_y", int'(bird_y), 3);
        do_tick(1, 1'b0);
        chk("ceiling_y", int'(bird_y), 0);
        do_tick(0, 1'b0);
        chk("after_ceiling_y", int'(bird_y), 1);

        // free fall to the ground, velocity capped, no wrap
        for (int i = 0; i < 60; i++) do_tick(0, 1'b0);
        chk("ground_y", int'(bird_y), 377);
        x = 10'd150; y = 9'd424; #1;
        chk("is_bird_ground_last_row", int'(is_bird), 1);
        y = 9'd425; #1;
        chk("is_bird_ground_below", int'(is_bird), 0);

        // rise in the tick cycle carries over to the next frame
        do_tick(0, 1'b1);
        chk("carry_same_tick_y", int'(bird_y), 377);
        do_tick(0, 1'b0);
        chk("carry_next_tick_y", int'(bird_y), 369);
        guard = 0;
        while (!(m_y == 377 && m_vel == 0) && guard < 80) begin
            do_tick(0, 1'b0);
            guard++;
        end
        chk("carry_return_ground", int'(bird_y), 377);

        // reach y=150 with vel=-5, then kill the bird
        for (int i = 0; i < 7; i++) begin pat.push_back(1); pat.push_back(0); end
        for (int i = 0; i < 13; i++) pat.push_back(1);
        for (int i = 0; i < 3; i++) pat.push_back(0);
        foreach (pat[i]) do_tick(pat[i], 1'b0);
        chk("pre_death_y", int'(bird_y), 150);
        chk("pre_death_vel", m_vel, -5);
        lose = 1'b1;
        @(negedge clk);
        m_state = 2; m_pend = 0;
        frame_at_death = m_frame;
        chk("death_state", int'(state), 2);
        chk("death_no_move", int'(bird_y), 150);
        do_tick(2, 1'b0);
        chk("dead_flap_ignored_y", int'(bird_y), 146);
        for (int i = 0; i < 45; i++) do_tick(2, 1'b0);
        chk("dead_rest_y", int'(bird_y), 377);
        chk("dead_anim_frozen", int'(anim_frame), frame_at_death);
        chk("dead_state_hold", int'(state), 2);

        // asynchronous reset mid-frame
        #2 RESET = 1'b1;
        #1;
        chk("async_rst_y", int'(bird_y), 200);
        chk("async_rst_state", int'(state), 0);
        chk("async_rst_anim", int'(anim_frame), 0);
        @(negedge clk);
        RESET = 1'b0; lose = 1'b0; game_status = 1'b0;
        model_reset();
        @(negedge clk);
        chk("post_rst_state", int'(state), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
